// File: rtl/sng.sv
// Stochastic number generator: encodes an unsigned magnitude as a unipolar bit
// stream by comparing the latched value against a maximal-length LFSR.
module sng #(
    parameter int WIDTH      = 4,
    parameter int SEED       = 1,
    parameter int STREAM_LEN = 0
) (
    input  logic             i_clk_sng,
    input  logic             i_rst_sng,
    input  logic [WIDTH-1:0] i_x_bn,
    input  logic             i_start_sng,
    input  logic             i_stop_sng,
    output logic             o_sn_bit,
    output logic             o_valid_sng
);

    // Tap masks over q[15:0] for Fibonacci shift-left LFSRs, one primitive polynomial per width.
    function automatic logic [15:0] tap_mask(input int w);
        case (w)
            3:       tap_mask = 16'h0006;
            4:       tap_mask = 16'h000C;
            5:       tap_mask = 16'h0014;
            6:       tap_mask = 16'h0030;
            7:       tap_mask = 16'h0060;
            8:       tap_mask = 16'h00B8;
            9:       tap_mask = 16'h0110;
            10:      tap_mask = 16'h0240;
            11:      tap_mask = 16'h0500;
            12:      tap_mask = 16'h0829;
            13:      tap_mask = 16'h100D;
            14:      tap_mask = 16'h2015;
            15:      tap_mask = 16'h6000;
            16:      tap_mask = 16'hD008;
            default: tap_mask = 16'h000C;
        endcase
    endfunction

    localparam logic [15:0]      TAPS16  = tap_mask(WIDTH);
    localparam logic [WIDTH-1:0] TAPS    = TAPS16[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_W  = WIDTH'(SEED);
    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [WIDTH-1:0] SEED_V  = (SEED_W == '0) ? WIDTH'(1) : SEED_W;
    localparam int               CNT_W   = (STREAM_LEN > 0) ? $clog2(STREAM_LEN + 1) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_lfsr;
    logic [WIDTH-1:0]   r_x_q;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_fb;
    logic [WIDTH-1:0]   w_lfsr_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_last;

    assign w_fb        = ^(r_lfsr & TAPS);
    assign w_lfsr_next = {r_lfsr[WIDTH-2:0], w_fb};
    assign w_cnt_next  = r_cnt + 1'b1;
    assign w_last      = (STREAM_LEN > 0) && (w_cnt_next == CNT_W'(STREAM_LEN));

    // Priority: stop over start over normal stepping; all outputs are registered.
    always_ff @(posedge i_clk_sng or posedge i_rst_sng) begin
        if (i_rst_sng) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            r_state     <= IDLE;
            r_lfsr      <= SEED_V;
            r_x_q       <= '0;
            r_cnt       <= '0;
            o_sn_bit    <= 1'b0;
            o_valid_sng <= 1'b0;
        end else if (i_stop_sng) begin
            r_state     <= IDLE;
            o_sn_bit    <= 1'b0;
            o_valid_sng <= 1'b0;
        end else if (i_start_sng) begin
            r_state     <= RUN;
            r_x_q       <= i_x_bn;
            r_lfsr      <= SEED_V;
            r_cnt       <= '0;
            o_sn_bit    <= 1'b0;
            o_valid_sng <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    o_sn_bit    <= 1'b0;
                    o_valid_sng <= 1'b0;
                end
                RUN: begin
                    o_sn_bit    <= (r_x_q >= r_lfsr);
                    o_valid_sng <= 1'b1;
                    r_lfsr      <= w_lfsr_next;
                    r_cnt       <= w_cnt_next;
                    if (w_last) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sng.sv
// Directed self-checking bench for sng (WIDTH=4): free-running and STREAM_LEN=20 instances.
module tb_sng;

    logic       clk;
    logic       rst;
    logic [3:0] x_in;
    logic       start;
    logic       stop;
    logic       sn, vld, sn20, vld20;

    int checks = 0;
    int errors = 0;

    // Expected LFSR sequence from SEED=1 for x^4+x^3+1.
    logic [3:0] seq [15] = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10,
                             4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8};
    // Hand-computed stream for x=5.
    logic       exp5 [15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                              1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    sng #(.WIDTH(4), .SEED(1), .STREAM_LEN(0)) u_dut (
        .i_clk_sng   (clk),
        .i_rst_sng   (rst),
        .i_x_bn      (x_in),
        .i_start_sng (start),
        .i_stop_sng  (stop),
        .o_sn_bit    (sn),
        .o_valid_sng (vld)
    );

    sng #(.WIDTH(4), .SEED(1), .STREAM_LEN(20)) u_dut20 (
        .i_clk_sng   (clk),
        .i_rst_sng   (rst),
        .i_x_bn      (x_in),
        .i_start_sng (start),
        .i_stop_sng  (stop),
        .o_sn_bit    (sn20),
        .o_valid_sng (vld20)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int ones;
        rst   = 1'b1;
        x_in  = 4'd0;
        start = 1'b0;
        stop  = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_sn", sn, 0);
        check("rst_vld", vld, 0);
        check("rst_sn20", sn20, 0);
        check("rst_vld20", vld20, 0);
        rst = 1'b0;
        tick();
        check("idle_vld", vld, 0);

        // x=5 stream, period 15, held for 5000 cycles; x_in changes mid-run are ignored
        x_in  = 4'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_edge_vld", vld, 0);
        check("start_edge_sn", sn, 0);
        for (int i = 0; i < 5000; i++) begin
            if (i == 2000) x_in = 4'd12;
            tick();
            check("x5_vld", vld, 1);
            check("x5_bit", sn, exp5[i % 15]);
        end

        // Stop mid-stream, then restart with x=9
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_sn", sn, 0);
        check("stop_vld", vld, 0);
        tick();
        check("stopped_vld", vld, 0);
        x_in  = 4'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("x9_start_vld", vld, 0);
        ones = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("x9_vld", vld, 1);
            check("x9_bit", sn, 32'(x_in >= seq[i]));
            ones += int'(sn);
        end
        check("x9_ones", ones, 9);

        // Start and stop together: stop wins, stays IDLE
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("startstop_vld", vld, 0);
        check("startstop_sn", sn, 0);
        tick();
        check("startstop_idle", vld, 0);

        // Sweep x=0..15; later iterations restart from RUN
        for (int x = 0; x < 16; x++) begin
            x_in  = 4'(x);
            start = 1'b1;
            tick();
            start = 1'b0;
            check("sweep_start_vld", vld, 0);
            check("sweep_start_sn", sn, 0);
            ones = 0;
            for (int i = 0; i < 15; i++) begin
                tick();
                check("sweep_vld", vld, 1);
                check("sweep_bit", sn, 32'(4'(x) >= seq[i]));
                ones += int'(sn);
            end
            check("sweep_ones", ones, x);
        end

        // STREAM_LEN=20 auto-stop with x=10
        stop = 1'b1;
        tick();
        stop  = 1'b0;
        x_in  = 4'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("len_start_vld", vld20, 0);
        ones = 0;
        for (int k = 1; k <= 26; k++) begin
            tick();
            if (k <= 20) begin
                check("len_vld", vld20, 1);
                check("len_bit", sn20, 32'(4'd10 >= seq[(k - 1) % 15]));
                ones += int'(sn20);
            end else begin
                check("len_after_vld", vld20, 0);
                check("len_after_sn", sn20, 0);
            end
        end
        check("len_ones", ones, 15);
        check("free_run_vld", vld, 1);

        // Asynchronous reset between edges while emitting ones
        x_in  = 4'd15;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre_arst_sn", sn, 1);
        check("pre_arst_vld", vld, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_sn", sn, 0);
        check("arst_vld", vld, 0);
        #1 rst = 1'b0;
        tick();
        check("post_arst_vld", vld, 0);
        x_in  = 4'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("arst_replay_vld", vld, 1);
            check("arst_replay_bit", sn, exp5[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sng.md
Name: sng

Overview:
- Stochastic number generator (SNG) for the stochastic-computing DCNN datapath.
- Converts an unsigned binary magnitude `i_x_bn` into a serial unipolar bit stream whose density of ones is `x/(2^WIDTH-1)`.
- Method: compare the latched input against a maximal-length LFSR.
- One instance per operand feeds the stochastic multiply/accumulate units.

Parameters:
- `WIDTH`, 4, bit width of `i_x_bn` and of the LFSR. Legal range 3..16.
- `SEED`, 1, LFSR load value at reset and at start. Zero is illegal; the RTL substitutes 1.
- `STREAM_LEN`, 0, number of stream bits before auto-stop. 0 = free-run until `i_stop_sng`.

Ports:
- `i_clk_sng`  in  1  clock; all state updates on the rising edge.
- `i_rst_sng`  in  1  reset, asynchronous, active-high.
- `i_x_bn`  in  WIDTH  binary value to encode; sampled only on start.
- `i_start_sng`  in  1  start pulse; begins or restarts a stream.
- `i_stop_sng`  in  1  stop request; ends the stream.
- `o_sn_bit`  out  1  stochastic bit stream, registered.
- `o_valid_sng`  out  1  high while `o_sn_bit` carries a stream bit.

Behaviour:
- One clock (`i_clk_sng`). Reset `i_rst_sng` is asynchronous and active-high.
- While reset is high:
  - state=IDLE
  - lfsr=SEED
  - x_q=0
  - cnt=0
  - `o_sn_bit`=0
  - `o_valid_sng`=0
- LFSR, Fibonacci, shift-left: next = {q[WIDTH-2:0], fb}.
  - fb = XOR of the maximal-length taps. For WIDTH=4: fb = q[3]^q[2] (x^4+x^3+1).
  - A fixed tap table covers WIDTH 3..16.
  - Period 2^WIDTH-1; never reaches 0.
- WIDTH=4 sequence from SEED=1: 1,2,4,9,3,6,13,10,5,11,7,15,14,12,8, then repeats.
- States: IDLE, RUN.
- IDLE:
  - `o_sn_bit`=0, `o_valid_sng`=0, lfsr held.
  - On an edge with `i_start_sng`=1: x_q<=`i_x_bn`, lfsr<=SEED, cnt<=0, state<=RUN.
- RUN, each edge:
  - `o_sn_bit`<=(x_q >= lfsr), unsigned compare.
  - `o_valid_sng`<=1.
  - lfsr<=next(lfsr), cnt<=cnt+1.
- Latency: the first stream bit appears after the second rising edge counted from the edge that samples start.
- Density: over any 2^WIDTH-1 consecutive RUN bits, the number of ones equals x_q exactly.
  - x=0 gives all zeros.
  - x=2^WIDTH-1 gives all ones.
- `i_stop_sng`=1 on an edge (any state) forces state<=IDLE, `o_sn_bit`<=0, `o_valid_sng`<=0. lfsr and x_q are held.
- Start and stop on the same edge: stop wins.
- Start while in RUN restarts the stream: reload SEED, relatch x, cnt=0. The output bit on that edge is 0 with `o_valid_sng`=0.
- Auto-stop when STREAM_LEN>0: on the edge where cnt reaches STREAM_LEN, the FSM returns to IDLE, so exactly STREAM_LEN valid bits are emitted. cnt is sized to hold STREAM_LEN.
- Changes on `i_x_bn` during RUN have no effect.
- Only a sampled 1 on start or stop acts. An undriven or unknown level on either input is not required to do anything defined; the bench drives both inputs.
- Reset asserted mid-stream returns all outputs to 0 immediately, without waiting for a clock edge.
- No combinational path from any input to any output.

Test Plan:
- Reset, then start with x=5, stop held at 0, WIDTH=4 -> first 15 valid bits are 1,1,1,0,1,0,0,0,1,0,0,0,0,0,0 (5 ones); the pattern repeats with period 15 for 5000 cycles.
- x=0 and x=15 -> `o_sn_bit` is constantly 0 and constantly 1 respectively while `o_valid_sng`=1.
- Sweep x=0..15, counting ones over 15 bits after start -> count == x for every value.
- Assert stop mid-stream, then start with x=9 -> outputs drop to 0 on the stop edge; the new stream restarts from SEED with 9 ones per 15 bits. Start+stop asserted together -> stays IDLE.
- STREAM_LEN=20, x=10 -> exactly 20 valid bits, `o_valid_sng` deasserts, `o_sn_bit`=0 afterwards.
- Assert reset asynchronously between clock edges during RUN -> `o_sn_bit`/`o_valid_sng` go 0 before the next edge; the next start reproduces the SEED sequence.
